spi_reg_access: RTL and testbench
=================================

// Module: spi_reg_access
// PURPOSE
//  Byte-level command decoder downstream of the SPI slave byte engine (clk domain).
//  Consumes received bytes (rx/byte_received) and turns each SSEL frame into register-bus
//  writes/reads with address auto-increment; supplies the next byte to shift out (tx/read_tx).
//  Frame: byte0 = {RW, ADDR[6:0]} (RW=1 write, 0 read); bytes 1..n = data.
// PARAMETERS
//  NUM_REGS     128    implemented addresses 0..NUM_REGS-1 (1..128)
//  STATUS_BYTE  8'hA5  tx value outside a frame and during byte0
//  OOR_BYTE     8'hFF  tx value returned for out-of-range reads
// PORTS
//  clk        in   1  system clock; everything registered on posedge clk
//  reset      in   1  asynchronous, active-high reset
//  SSEL       in   1  raw SPI chip select, active low; synchronised internally (2 FF)
//  rx         in   8  received byte; valid while byte_received=1
//  byte_received in 1 one-cycle pulse per received byte
//  tx         out  8  byte the SPI slave loads at next byte start
//  read_tx    out  1  one-cycle pulse: tx has just been updated
//  wr_en      out  1  one-cycle register write strobe
//  wr_addr    out  7  write address
//  wr_data    out  8  write data
//  rd_en      out  1  one-cycle register read strobe
//  rd_addr    out  7  read address
//  rd_data    in   8  read data, valid exactly 1 cycle after rd_en
//  cmd_err    out  1  sticky: out-of-range access in current frame; cleared at frame start
// BEHAVIOUR
//  Reset: state=IDLE, tx=STATUS_BYTE, addr=0, all strobes/read_tx/cmd_err=0, wr_*/rd_addr=0.
//  frame_act = ~SSEL after 2-FF sync. frame_act=0 forces IDLE within 1 cycle; tx<=STATUS_BYTE.
//  States: IDLE -> CMD on frame_act rise (cmd_err<=0). CMD: on byte_received latch
//   addr<=rx[6:0], rw<=rx[7]; RW=1 -> WR; RW=0 -> RD_REQ. RD_REQ(1 cyc) -> RD_CAP(1 cyc) -> RD.
//  WR: byte_received at cycle T -> at T+1 wr_en=1, wr_addr=addr, wr_data=rx(T); addr<=addr+1.
//   tx held at 8'h00 in WR.
//  RD_REQ: rd_en=1, rd_addr=addr for one cycle. RD_CAP: tx<=rd_data, read_tx=1 next cycle,
//   addr<=addr+1. RD: each byte_received (master's dummy byte, ignored) -> RD_REQ.
//   Latency byte_received(T) -> tx valid T+3; rd_en at T+1.
//  Out of range (addr>=NUM_REGS): write -> no wr_en, cmd_err<=1; read -> no rd_en,
//   tx<=OOR_BYTE with read_tx pulse at same latency, cmd_err<=1. addr still increments.
//  addr wraps 7'h7F -> 7'h00 (7-bit modulo); no error from wrap itself.
//  byte_received while in RD_REQ/RD_CAP: dropped (master must allow >=4 clk between bytes).
//  byte_received and frame_act fall in same cycle: frame end wins, byte discarded, no strobe.
//  byte_received in IDLE: ignored. Bytes beyond frame: none; every new frame restarts at CMD.
//  Reset asserted mid-frame: immediate return to reset values, no partial strobe on release.
//  wr_en, rd_en, read_tx never high >1 consecutive cycle per byte; wr_en & rd_en never both 1.
// TESTING
//  1 Reset: assert reset mid-WR -> all outputs at reset values, tx=8'hA5, no wr_en after release.
//  2 Write burst: SSEL low, bytes 8'h85,8'h11,8'h22 -> wr_en at (5,8'h11),(6,8'h22), tx=8'h00.
//  3 Read burst: bytes 8'h10,8'h00,8'h00 with rd_data=addr+8'h40 -> rd_en addr 16,17,18;
//    tx sequence 8'h50,8'h51,8'h52, each with a read_tx pulse 3 cycles after byte_received.
//  4 Out of range, NUM_REGS=16: bytes 8'h8F,8'hAA,8'hBB -> wr_en at addr 15 only; cmd_err=1
//    after 2nd data byte; next frame start clears cmd_err.
//  5 Wrap: read cmd 8'h7F, NUM_REGS=128 -> rd_addr 7F then 00, no cmd_err.
//  6 SSEL rises same cycle as byte_received in WR -> no wr_en, tx returns to 8'hA5, IDLE.

Source files
------------

// File: rtl/spi_reg_access.sv
// Byte-level command decoder behind an SPI slave byte engine. It turns each SSEL frame into
// register-bus writes or reads with address auto-increment, and supplies the next byte to shift out.
module spi_reg_access #(
  parameter int         NUM_REGS    = 128,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] OOR_BYTE    = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SSEL,
  input  logic [7:0] rx,
  input  logic       byte_received,
  output logic [7:0] tx,
  output logic       read_tx,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_CAP,
    RD
  } state_t;

  state_t     state;
  logic [6:0] addr;
  logic       ssel_meta;
  logic       ssel_sync;
  logic       frame_act;

  function automatic logic in_range(input logic [6:0] a);
    return ({25'd0, a} < 32'(NUM_REGS));
  endfunction

  // NOTE: the synchroniser resets to the inactive (high) level so that releasing reset
  // with SSEL already low is seen as a fresh frame start, never as a frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_meta <= 1'b1;
      ssel_sync <= 1'b1;
    end else begin
      ssel_meta <= SSEL;
      ssel_sync <= ssel_meta;
    end
  end

  assign frame_act = ~ssel_sync;

  // NOTE: strobes default low at the top of every cycle, so each one is a single-cycle
  // pulse unless a branch below explicitly re-asserts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      tx      <= STATUS_BYTE;
      read_tx <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      cmd_err <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      read_tx <= 1'b0;

      // Frame end has priority over any byte arriving in the same cycle.
      if (!frame_act) begin
        state <= IDLE;
        tx    <= STATUS_BYTE;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= CMD;
            tx      <= STATUS_BYTE;
            cmd_err <= 1'b0;
          end

          CMD: begin
            if (byte_received) begin
              addr <= rx[6:0];
              if (rx[7]) begin
                state <= WR;
                tx    <= 8'h00;
              end else begin
                state   <= RD_REQ;
                rd_en   <= in_range(rx[6:0]);
                rd_addr <= rx[6:0];
              end
            end
          end

          WR: begin
            if (byte_received) begin
              if (in_range(addr)) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= rx;
              end else begin
                cmd_err <= 1'b1;
              end
              addr <= addr + 7'd1;
            end
          end

          RD_REQ: state <= RD_CAP;

          // rd_data is valid here, exactly one cycle after rd_en.
          RD_CAP: begin
            if (in_range(addr)) begin
              tx <= rd_data;
            end else begin
              tx      <= OOR_BYTE;
              cmd_err <= 1'b1;
            end
            read_tx <= 1'b1;
            addr    <= addr + 7'd1;
            state   <= RD;
          end

          RD: begin
            if (byte_received) begin
              state   <= RD_REQ;
              rd_en   <= in_range(addr);
              rd_addr <= addr;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_access.sv
// Scoreboard bench for spi_reg_access: expected bus events are queued with their due cycle
// when bytes are driven, then popped and compared as the DUT strobes them.
module tb_spi_reg_access;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ssel = 1'b1;
  logic       byte_received = 1'b0;
  logic [7:0] rx = 8'h00;

  logic [7:0] tx_a, wr_data_a, rd_data_a;
  logic [6:0] wr_addr_a, rd_addr_a;
  logic       read_tx_a, wr_en_a, rd_en_a, cmd_err_a;
  logic [7:0] tx_b, wr_data_b, rd_data_b;
  logic [6:0] wr_addr_b, rd_addr_b;
  logic       read_tx_b, wr_en_b, rd_en_b, cmd_err_b;

  spi_reg_access #(.NUM_REGS(128)) dut (
    .clk(clk), .reset(reset), .SSEL(ssel), .rx(rx), .byte_received(byte_received),
    .tx(tx_a), .read_tx(read_tx_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .cmd_err(cmd_err_a)
  );

  spi_reg_access #(.NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .SSEL(ssel), .rx(rx), .byte_received(byte_received),
    .tx(tx_b), .read_tx(read_tx_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .cmd_err(cmd_err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file responders: data = addr + 8'h40, valid only in the cycle after rd_en.
  logic       pend_a = 1'b0, pend_b = 1'b0;
  logic [7:0] val_a = 8'h00, val_b = 8'h00;
  initial begin
    rd_data_a = 8'hEE;
    rd_data_b = 8'hEE;
    forever begin
      @(posedge clk);
      #1;
      rd_data_a = pend_a ? val_a : 8'hEE;
      rd_data_b = pend_b ? val_b : 8'hEE;
      pend_a    = rd_en_a;
      pend_b    = rd_en_b;
      val_a     = {1'b0, rd_addr_a} + 8'h40;
      val_b     = {1'b0, rd_addr_b} + 8'h40;
    end
  end

  typedef enum logic [1:0] {E_WR, E_RD, E_TX} ekind_t;
  typedef struct {
    ekind_t     kind;
    logic [6:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  logic sel16 = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic pop_cmp(input string tag, input ekind_t k, input logic [6:0] a,
                         input logic [7:0] d, input logic use_a, input logic use_d);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check({tag, "_kind"}, 32'(k), 32'(e.kind));
      if (use_a) check({tag, "_addr"}, 32'(a), 32'(e.addr));
      if (use_d) check({tag, "_data"}, 32'(d), 32'(e.data));
      check({tag, "_cycle"}, cyc, e.due);
    end
  endtask

  // Monitor samples on the falling edge; it watches whichever instance the test selects.
  always @(negedge clk) begin
    logic       m_wr, m_rd, m_tx;
    logic [6:0] m_wa, m_ra;
    logic [7:0] m_wd, m_t;
    m_wr = sel16 ? wr_en_b   : wr_en_a;
    m_rd = sel16 ? rd_en_b   : rd_en_a;
    m_tx = sel16 ? read_tx_b : read_tx_a;
    m_wa = sel16 ? wr_addr_b : wr_addr_a;
    m_ra = sel16 ? rd_addr_b : rd_addr_a;
    m_wd = sel16 ? wr_data_b : wr_data_a;
    m_t  = sel16 ? tx_b      : tx_a;
    if (m_wr && m_rd) check("wr_rd_exclusive", 32'd1, 32'd0);
    if (m_wr) pop_cmp("wr", E_WR, m_wa, m_wd, 1'b1, 1'b1);
    if (m_rd) pop_cmp("rd", E_RD, m_ra, 8'h00, 1'b1, 1'b0);
    if (m_tx) pop_cmp("tx", E_TX, 7'h00, m_t, 1'b0, 1'b1);
  end

  // Drive one byte; queue the events it must cause relative to the byte cycle N.
  task automatic send(input logic [7:0] b, input logic do_wr, input logic do_rd,
                      input logic do_tx, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    rx = b;
    byte_received = 1'b1;
    if (do_wr) begin e.kind = E_WR; e.addr = a; e.data = d; e.due = cyc + 1; q.push_back(e); end
    if (do_rd) begin e.kind = E_RD; e.addr = a; e.data = 8'h00; e.due = cyc + 1; q.push_back(e); end
    if (do_tx) begin e.kind = E_TX; e.addr = 7'h00; e.data = d; e.due = cyc + 3; q.push_back(e); end
    @(posedge clk);
    #1;
    byte_received = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1 ssel = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk);
    #1 ssel = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_tx"},      32'(tx_a),      32'hA5);
    check({p, "_read_tx"}, 32'(read_tx_a), 32'd0);
    check({p, "_wr_en"},   32'(wr_en_a),   32'd0);
    check({p, "_rd_en"},   32'(rd_en_a),   32'd0);
    check({p, "_cmd_err"}, 32'(cmd_err_a), 32'd0);
    check({p, "_wr_addr"}, 32'(wr_addr_a), 32'd0);
    check({p, "_wr_data"}, 32'(wr_data_a), 32'd0);
    check({p, "_rd_addr"}, 32'(rd_addr_a), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    // Write burst starting at address 5.
    frame_start();
    send(8'h85, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clk);
    check("wr_tx_zero", 32'(tx_a), 32'h00);
    send(8'h11, 1'b1, 1'b0, 1'b0, 7'd5, 8'h11);
    send(8'h22, 1'b1, 1'b0, 1'b0, 7'd6, 8'h22);
    frame_end();
    @(negedge clk);
    check("wr_end_tx_status", 32'(tx_a), 32'hA5);
    check("wr_drained", q.size(), 0);

    // Read burst starting at address 16.
    frame_start();
    @(negedge clk);
    check("cmd_tx_status", 32'(tx_a), 32'hA5);
    send(8'h10, 1'b0, 1'b1, 1'b1, 7'd16, 8'h50);
    send(8'h00, 1'b0, 1'b1, 1'b1, 7'd17, 8'h51);
    send(8'h00, 1'b0, 1'b1, 1'b1, 7'd18, 8'h52);
    @(negedge clk);
    check("rd_tx_last", 32'(tx_a), 32'h52);
    frame_end();
    check("rd_drained", q.size(), 0);

    // Address wrap 7F -> 00 on reads.
    frame_start();
    send(8'h7F, 1'b0, 1'b1, 1'b1, 7'h7F, 8'hBF);
    send(8'h00, 1'b0, 1'b1, 1'b1, 7'h00, 8'h40);
    @(negedge clk);
    check("wrap_cmd_err", 32'(cmd_err_a), 32'd0);
    frame_end();
    check("wrap_drained", q.size(), 0);

    // Out of range on the 16-register instance.
    sel16 = 1'b1;
    frame_start();
    send(8'h8F, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    send(8'hAA, 1'b1, 1'b0, 1'b0, 7'd15, 8'hAA);
    @(negedge clk);
    check("oor_err_before", 32'(cmd_err_b), 32'd0);
    send(8'hBB, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clk);
    check("oor_wr_err", 32'(cmd_err_b), 32'd1);
    frame_end();
    @(negedge clk);
    check("oor_err_sticky", 32'(cmd_err_b), 32'd1);
    frame_start();
    @(negedge clk);
    check("oor_err_cleared", 32'(cmd_err_b), 32'd0);
    send(8'h20, 1'b0, 1'b0, 1'b1, 7'h00, 8'hFF);
    @(negedge clk);
    check("oor_rd_err", 32'(cmd_err_b), 32'd1);
    frame_end();
    check("oor_drained", q.size(), 0);
    sel16 = 1'b0;

    // SSEL rises so frame_act falls in the same cycle as a data byte.
    frame_start();
    send(8'h85, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(posedge clk);
    #1 ssel = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rx = 8'h77;
    byte_received = 1'b1;
    @(posedge clk);
    #1 byte_received = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("race_tx_status", 32'(tx_a), 32'hA5);
    frame_start();
    send(8'h03, 1'b0, 1'b1, 1'b1, 7'd3, 8'h43);
    frame_end();
    check("race_drained", q.size(), 0);

    // Reset asserted mid-write together with a pending byte.
    frame_start();
    send(8'h85, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    send(8'h33, 1'b1, 1'b0, 1'b0, 7'd5, 8'h33);
    @(posedge clk);
    #1;
    rx = 8'h44;
    byte_received = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(posedge clk);
    #1 byte_received = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst_no_wr", 32'(wr_en_a), 32'd0);
    check("rst_tx_status", 32'(tx_a), 32'hA5);
    frame_end();
    check("rst_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
